// File: rtl/usb_pkg.sv
// Shared USB line definitions: bus levels, their dp/dm encodings and the
// transmit FSM state type.
package usb_pkg;

  typedef enum logic [1:0] {
    BUS_J,
    BUS_K,
    BUS_SE0
  } bus_state_t;

  // {dp, dm} for each full-speed bus level
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_DATA,
    TX_STUFF,
    TX_EOP_SE0,
    TX_EOP_J
  } tx_state_t;

  function automatic logic [1:0] bus_line(input bus_state_t lvl);
    logic [1:0] line;
    case (lvl)
      BUS_K:   line = LINE_K;
      BUS_SE0: line = LINE_SE0;
      default: line = LINE_J;
    endcase
    return line;
  endfunction

endpackage

// File: rtl/nrzi_enc.sv
// NRZI line-level holder. Keeps the current bus level and drives dp/dm from
// registers so the transceiver never sees combinational glitches.
module nrzi_enc
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic toggle,
  input  logic hold,
  input  logic force_se0,
  input  logic force_j,
  output logic dp,
  output logic dm
);

  bus_state_t lvl_q;
  bus_state_t lvl_d;
  logic [1:0] line_d;

  // Next level: EOP forcing wins, a hold freezes the line, otherwise toggle J<->K.
  always_comb begin
    lvl_d = lvl_q;
    if (force_se0) begin
      lvl_d = BUS_SE0;
    end else if (force_j) begin
      lvl_d = BUS_J;
    end else if (toggle && !hold) begin
      lvl_d = (lvl_q == BUS_K) ? BUS_J : BUS_K;
    end
    line_d = bus_line(lvl_d);
  end

  // Level and line registers; reset leaves the bus idle (J).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lvl_q <= BUS_J;
      dp    <= 1'b1;
      dm    <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      dp    <= line_d[1];
      dm    <= line_d[0];
    end
  end

endmodule

// File: rtl/usb_bitstuff_nrzi.sv
// USB transmit line stage: bit stuffing, NRZI encoding and EOP generation.
//
// state      | meaning
// TX_IDLE    | line J, transceiver off, waiting for stream_begin
// TX_DATA    | accepting serial bits, pause low
// TX_STUFF   | one cycle emitting the stuffed 0, upstream paused
// TX_EOP_SE0 | driving SE0 (line lags state by one cycle)
// TX_EOP_J   | driving the closing J, then eop_done and out_en drop
//
// The line is one edge behind the state, so the EOP counters are aligned to
// what is actually on dp/dm: SE0 is visible for EOP_SE0_BITS cycles and the J
// bit is visible for one cycle with out_en still high; eop_done and out_en=0
// appear together on the edge that completes that J bit.
module usb_bitstuff_nrzi
  import usb_pkg::*;
#(
  parameter int STUFF_RUN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic stream_begin,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic stream_done,
  output logic pause,
  output logic dp,
  output logic dm,
  output logic out_en,
  output logic eop_done
);

  localparam int CW = $clog2(STUFF_RUN + 1);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] ones_cnt, ones_d;
  logic [EW-1:0] eop_cnt, eop_d;
  logic          done_pend, done_pend_d;
  logic          out_en_d, eop_done_d;
  logic          toggle, hold, force_se0, force_j;
  logic [CW-1:0] ones_inc;

  assign ones_inc = ones_cnt + 1'b1;
  assign pause    = (state_q != TX_DATA);

  // Next-state, counter and line-control decode.
  always_comb begin
    state_d     = state_q;
    ones_d      = ones_cnt;
    eop_d       = eop_cnt;
    done_pend_d = done_pend;
    out_en_d    = out_en;
    eop_done_d  = 1'b0;
    toggle      = 1'b0;
    hold        = 1'b0;
    force_se0   = 1'b0;
    force_j     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        force_j  = 1'b1;
        out_en_d = 1'b0;
        if (stream_begin) begin
          state_d     = TX_DATA;
          out_en_d    = 1'b1;
          ones_d      = '0;
          done_pend_d = 1'b0;
        end
      end
      TX_DATA: begin
        if (!bit_valid) begin
          hold = 1'b1;
        end else if (!bit_in) begin
          toggle = 1'b1;
          ones_d = '0;
          if (stream_done) begin
            state_d = TX_EOP_SE0;
            eop_d   = '0;
          end
        end else begin
          ones_d = ones_inc;
          if (ones_inc == CW'(STUFF_RUN)) begin
            state_d     = TX_STUFF;
            done_pend_d = stream_done;
          end else if (stream_done) begin
            state_d = TX_EOP_SE0;
            eop_d   = '0;
          end
        end
      end
      TX_STUFF: begin
        toggle = 1'b1;
        ones_d = '0;
        if (done_pend) begin
          state_d     = TX_EOP_SE0;
          eop_d       = '0;
          done_pend_d = 1'b0;
        end else begin
          state_d = TX_DATA;
        end
      end
      TX_EOP_SE0: begin
        force_se0 = 1'b1;
        if (eop_cnt == EW'(EOP_SE0_BITS - 1)) begin
          state_d = TX_EOP_J;
          eop_d   = '0;
        end else begin
          eop_d = eop_cnt + 1'b1;
        end
      end
      TX_EOP_J: begin
        force_j = 1'b1;
        if (eop_cnt == '0) begin
          eop_d = EW'(1);
        end else begin
          state_d    = TX_IDLE;
          eop_done_d = 1'b1;
          out_en_d   = 1'b0;
          eop_d      = '0;
        end
      end
      default: begin
        state_d  = TX_IDLE;
        out_en_d = 1'b0;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= TX_IDLE;
      ones_cnt  <= '0;
      eop_cnt   <= '0;
      done_pend <= 1'b0;
      out_en    <= 1'b0;
      eop_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_cnt  <= ones_d;
      eop_cnt   <= eop_d;
      done_pend <= done_pend_d;
      out_en    <= out_en_d;
      eop_done  <= eop_done_d;
    end
  end

  nrzi_enc u_nrzi_enc (
    .clk       (clk),
    .rst_b     (rst_b),
    .toggle    (toggle),
    .hold      (hold),
    .force_se0 (force_se0),
    .force_j   (force_j),
    .dp        (dp),
    .dm        (dm)
  );

endmodule

// File: tb/tb_usb_bitstuff_nrzi.sv
// Directed bench for usb_bitstuff_nrzi. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_usb_bitstuff_nrzi;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst_b;
  logic stream_begin, bit_in, bit_valid, stream_done;
  logic pause, dp, dm, out_en, eop_done;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  usb_bitstuff_nrzi dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .stream_begin (stream_begin),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .stream_done  (stream_done),
    .pause        (pause),
    .dp           (dp),
    .dm           (dm),
    .out_en       (out_en),
    .eop_done     (eop_done)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bit per call: drive at the falling edge, let one rising edge pass.
  task automatic send(input logic b, input logic v, input logic d);
    bit_in = b; bit_valid = v; stream_done = d;
    @(negedge clk);
    bit_in = 1'b0; bit_valid = 1'b0; stream_done = 1'b0;
  endtask

  task automatic begin_pkt(input string tag);
    stream_begin = 1'b1;
    @(negedge clk);
    stream_begin = 1'b0;
    chk({tag, " begin line"}, {6'd0, dp, dm}, {6'd0, J});
    chk({tag, " begin out_en"}, {7'd0, out_en}, 8'd1);
    chk({tag, " begin pause"}, {7'd0, pause}, 8'd0);
    chk({tag, " begin ones"}, {5'd0, dut.ones_cnt}, 8'd0);
  endtask

  // Called on the falling edge where the last bit (or stuffed 0) is on the line.
  task automatic check_eop(input string tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, " eop se0"}, {6'd0, dp, dm}, {6'd0, SE0});
      chk({tag, " eop se0 out_en"}, {7'd0, out_en}, 8'd1);
    end
    @(negedge clk);
    chk({tag, " eop j"}, {6'd0, dp, dm}, {6'd0, J});
    chk({tag, " eop j out_en"}, {7'd0, out_en}, 8'd1);
    chk({tag, " eop j done"}, {7'd0, eop_done}, 8'd0);
    @(negedge clk);
    chk({tag, " eop_done"}, {7'd0, eop_done}, 8'd1);
    chk({tag, " eop out_en off"}, {7'd0, out_en}, 8'd0);
    chk({tag, " eop idle line"}, {6'd0, dp, dm}, {6'd0, J});
    chk({tag, " eop idle pause"}, {7'd0, pause}, 8'd1);
  endtask

  initial begin
    rst_b = 1'b0;
    stream_begin = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; stream_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst line", {6'd0, dp, dm}, {6'd0, J});
    chk("rst out_en", {7'd0, out_en}, 8'd0);
    chk("rst eop_done", {7'd0, eop_done}, 8'd0);
    chk("rst pause", {7'd0, pause}, 8'd1);
    chk("rst ones", {5'd0, dut.ones_cnt}, 8'd0);
    rst_b = 1'b1;
    // bit_valid while idle must not start anything
    send(1'b0, 1'b1, 1'b0);
    chk("idle valid line", {6'd0, dp, dm}, {6'd0, J});
    chk("idle valid pause", {7'd0, pause}, 8'd1);

    // 1: 0,0,1,1 -> K,J,J,J
    begin_pkt("t1");
    send(1'b0, 1'b1, 1'b0); chk("t1 b0", {6'd0, dp, dm}, {6'd0, K});
    send(1'b0, 1'b1, 1'b0); chk("t1 b1", {6'd0, dp, dm}, {6'd0, J});
    send(1'b1, 1'b1, 1'b0); chk("t1 b2", {6'd0, dp, dm}, {6'd0, J});
    send(1'b1, 1'b1, 1'b0); chk("t1 b3", {6'd0, dp, dm}, {6'd0, J});
    chk("t1 out_en", {7'd0, out_en}, 8'd1);
    chk("t1 ones", {5'd0, dut.ones_cnt}, 8'd2);
    send(1'b0, 1'b1, 1'b1); chk("t1 last", {6'd0, dp, dm}, {6'd0, K});
    check_eop("t1");

    // 2: seven 1s then a 0, stuff after the sixth
    begin_pkt("t2");
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, 1'b0);
      chk("t2 ones line", {6'd0, dp, dm}, {6'd0, J});
    end
    chk("t2 stuff pause", {7'd0, pause}, 8'd1);
    chk("t2 ones6", {5'd0, dut.ones_cnt}, 8'd6);
    bit_in = 1'b1; bit_valid = 1'b1;
    @(negedge clk);
    chk("t2 stuff line", {6'd0, dp, dm}, {6'd0, K});
    chk("t2 pause released", {7'd0, pause}, 8'd0);
    chk("t2 ones after stuff", {5'd0, dut.ones_cnt}, 8'd0);
    @(negedge clk);
    bit_valid = 1'b0;
    chk("t2 seventh line", {6'd0, dp, dm}, {6'd0, K});
    chk("t2 seventh ones", {5'd0, dut.ones_cnt}, 8'd1);
    send(1'b0, 1'b1, 1'b1); chk("t2 last", {6'd0, dp, dm}, {6'd0, J});
    check_eop("t2");

    // 3: sixth 1 carries stream_done -> stuff then EOP
    begin_pkt("t3");
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    chk("t3 stuff pause", {7'd0, pause}, 8'd1);
    chk("t3 pre-stuff line", {6'd0, dp, dm}, {6'd0, J});
    @(negedge clk);
    chk("t3 stuff line", {6'd0, dp, dm}, {6'd0, K});
    chk("t3 pause in eop", {7'd0, pause}, 8'd1);
    check_eop("t3");

    // 4: 1,-,1,-,0 with gaps
    begin_pkt("t4");
    send(1'b1, 1'b1, 1'b0); chk("t4 b0", {6'd0, dp, dm}, {6'd0, J});
    send(1'b1, 1'b0, 1'b0); chk("t4 gap0", {6'd0, dp, dm}, {6'd0, J});
    chk("t4 gap0 ones", {5'd0, dut.ones_cnt}, 8'd1);
    send(1'b1, 1'b1, 1'b0); chk("t4 b1 ones", {5'd0, dut.ones_cnt}, 8'd2);
    send(1'b0, 1'b0, 1'b1); chk("t4 gap1", {6'd0, dp, dm}, {6'd0, J});
    chk("t4 gap1 ones", {5'd0, dut.ones_cnt}, 8'd2);
    chk("t4 gap1 pause", {7'd0, pause}, 8'd0);
    send(1'b0, 1'b1, 1'b0); chk("t4 b2", {6'd0, dp, dm}, {6'd0, K});
    chk("t4 b2 ones", {5'd0, dut.ones_cnt}, 8'd0);
    send(1'b0, 1'b1, 1'b1); chk("t4 last", {6'd0, dp, dm}, {6'd0, J});
    check_eop("t4");

    // 5: stream_begin in DATA ignored, reset during EOP_SE0
    begin_pkt("t5");
    stream_begin = 1'b1;
    send(1'b1, 1'b1, 1'b0);
    stream_begin = 1'b0;
    chk("t5 ign line", {6'd0, dp, dm}, {6'd0, J});
    chk("t5 ign ones", {5'd0, dut.ones_cnt}, 8'd1);
    chk("t5 ign pause", {7'd0, pause}, 8'd0);
    send(1'b0, 1'b1, 1'b1); chk("t5 last", {6'd0, dp, dm}, {6'd0, K});
    @(negedge clk);
    chk("t5 se0", {6'd0, dp, dm}, {6'd0, SE0});
    #2 rst_b = 1'b0;
    #1;
    chk("t5 async line", {6'd0, dp, dm}, {6'd0, J});
    chk("t5 async out_en", {7'd0, out_en}, 8'd0);
    chk("t5 async pause", {7'd0, pause}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5 no eop_done", {7'd0, eop_done}, 8'd0);
    end
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5 post rst eop_done", {7'd0, eop_done}, 8'd0);
      chk("t5 post rst line", {6'd0, dp, dm}, {6'd0, J});
    end

    // 6: back-to-back packets
    begin_pkt("t6a");
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1); chk("t6a last", {6'd0, dp, dm}, {6'd0, K});
    check_eop("t6a");
    begin_pkt("t6b");
    send(1'b0, 1'b1, 1'b0); chk("t6b b0", {6'd0, dp, dm}, {6'd0, K});
    chk("t6b eop_done low", {7'd0, eop_done}, 8'd0);
    send(1'b1, 1'b1, 1'b1); chk("t6b last", {6'd0, dp, dm}, {6'd0, K});
    check_eop("t6b");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
